// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared constants, types and helpers for the 8-way cache PLRU logic.
//   WAYS / WAYS_REP / INDEX / SETS : associativity, way-index width,
//                                    set-index width, number of sets
//   plru_t, way_t, set_t           : tree bits, way index, set index
//   plru_op_t                      : TOUCH (hit/fill) or DEMOTE (invalidate)
//   clr_state_t                    : sweep-clear FSM states
//   plru_victim()                  : victim decode of a PLRU tree
//   set_in_range()                 : guards set indices when SETS < 2**INDEX
// ----------------------------------------------------------------------------
package cache_pkg;

  localparam int WAYS     = 8;
  localparam int WAYS_REP = 3;
  localparam int INDEX    = 14;
  localparam int SETS     = 2**INDEX;

  typedef logic [WAYS-2:0]     plru_t;
  typedef logic [WAYS_REP-1:0] way_t;
  typedef logic [INDEX-1:0]    set_t;

  typedef enum logic {TOUCH = 1'b0, DEMOTE = 1'b1} plru_op_t;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  // Victim decode (same decode as Cache_get_PLRU). A tree bit of 1 steers
  // the victim toward the lower-numbered half, so each way-index bit is the
  // complement of the tree bit visited at that level.
  function automatic way_t plru_victim(plru_t t);
    way_t w;
    w[2] = ~t[0];
    w[1] = w[2] ? ~t[2] : ~t[1];
    case (w[2:1])
      2'd0:    w[0] = ~t[3];
      2'd1:    w[0] = ~t[4];
      2'd2:    w[0] = ~t[5];
      default: w[0] = ~t[6];
    endcase
    return w;
  endfunction

  // Always true with the full 2**INDEX set count; kept so a smaller SETS
  // drops out-of-range requests instead of aliasing onto real sets.
  function automatic logic set_in_range(set_t s);
    if (SETS >= 2**INDEX) return 1'b1;
    return (int'(s) < SETS);
  endfunction

endpackage

// File: rtl/plru_tree_update.sv
// ----------------------------------------------------------------------------
// plru_tree_update
// Pure combinational PLRU tree rewrite for one access.
//   old_bits : current tree of the set
//   way      : way touched or demoted
//   op       : TOUCH points the three path bits away from way,
//              DEMOTE points them at way (making it the victim)
//   new_bits : rewritten tree; bits off the path are unchanged
// ----------------------------------------------------------------------------
module plru_tree_update
  import cache_pkg::*;
(
  input  plru_t    old_bits,
  input  way_t     way,
  input  plru_op_t op,
  output plru_t    new_bits
);

  logic pol;

  always_comb begin
    new_bits = old_bits;
    // For TOUCH each path bit equals the way-index bit at that level
    // (pointing away from the accessed half); DEMOTE inverts that.
    pol = (op == DEMOTE);
    new_bits[0] = way[2] ^ pol;
    if (way[2]) begin
      new_bits[2] = way[1] ^ pol;
    end else begin
      new_bits[1] = way[1] ^ pol;
    end
    case (way[2:1])
      2'd0:    new_bits[3] = way[0] ^ pol;
      2'd1:    new_bits[4] = way[0] ^ pol;
      2'd2:    new_bits[5] = way[0] ^ pol;
      default: new_bits[6] = way[0] ^ pol;
    endcase
  end

endmodule

// File: rtl/cache_plru_update.sv
// ----------------------------------------------------------------------------
// cache_plru_update
// Per-set pseudo-LRU state keeper for the 8-way set-associative cache.
// Holds a 7-bit PLRU tree per set, rewrites it on TOUCH/DEMOTE updates and
// returns a registered victim for queried sets.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/op/set/way, req_ready : tree update request (op 0=TOUCH, 1=DEMOTE)
//   qry_valid, qry_set: victim query
//   victim_valid/way/bits : registered query result, one cycle after accept
//   clr_start, clr_busy   : full-array sweep clear (SETS cycles)
// ----------------------------------------------------------------------------
module cache_plru_update
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_op,
  input  logic [INDEX-1:0]    req_set,
  input  logic [WAYS_REP-1:0] req_way,
  output logic                req_ready,
  input  logic                qry_valid,
  input  logic [INDEX-1:0]    qry_set,
  output logic                victim_valid,
  output logic [WAYS_REP-1:0] victim_way,
  output logic [WAYS-2:0]     victim_bits,
  input  logic                clr_start,
  output logic                clr_busy
);

  localparam set_t LAST_SET = set_t'(SETS - 1);

  // Tree storage is a register array: reset must clear every set at once and
  // the update path reads the old tree in the same cycle it writes the new one.
  plru_t tree_mem [SETS];

  clr_state_t state_reg, state_next;
  set_t       cnt_reg, cnt_next;
  logic       clr_wr;

  logic  victim_valid_reg;
  way_t  victim_way_reg;
  plru_t victim_bits_reg;

  logic  req_acc, qry_acc;
  plru_t upd_bits, fwd_bits;

  // --------------------------------------------------------------------------
  // Sweep-clear FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_wr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        // clr_start is deliberately not looked at here.
        clr_wr = 1'b1;
        if (cnt_reg == LAST_SET) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign clr_busy  = (state_reg == CLEAR);
  assign req_ready = ~clr_busy;

  // --------------------------------------------------------------------------
  // Update and query acceptance
  // --------------------------------------------------------------------------
  assign req_acc = req_valid & req_ready & set_in_range(req_set);
  assign qry_acc = qry_valid & ~clr_busy & set_in_range(qry_set);

  plru_tree_update u_upd (
    .old_bits (tree_mem[req_set]),
    .way      (req_way),
    .op       (plru_op_t'(req_op)),
    .new_bits (upd_bits)
  );

  // Write-first: a query to the set being updated this cycle sees the new tree.
  assign fwd_bits = (req_acc && (req_set == qry_set)) ? upd_bits : tree_mem[qry_set];

  // --------------------------------------------------------------------------
  // Tree array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        tree_mem[i] <= '0;
      end
    end else if (clr_wr) begin
      tree_mem[cnt_reg] <= '0;
    end else if (req_acc) begin
      tree_mem[req_set] <= upd_bits;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state and victim registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      victim_valid_reg <= 1'b0;
      victim_way_reg   <= '0;
      victim_bits_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      victim_valid_reg <= qry_acc;
      // Without an accepted query the previous result is held.
      if (qry_acc) begin
        victim_bits_reg <= fwd_bits;
        victim_way_reg  <= plru_victim(fwd_bits);
      end
    end
  end

  assign victim_valid = victim_valid_reg;
  assign victim_way   = victim_way_reg;
  assign victim_bits  = victim_bits_reg;

endmodule

// File: tb/tb_cache_plru_update.sv
// ----------------------------------------------------------------------------
// tb_cache_plru_update
// Directed and randomized bench for cache_plru_update. The reference model
// keeps each set's tree as a heap-indexed binary tree (children of node n are
// 2n+1 and 2n+2) and walks it from the root for updates and victims.
// ----------------------------------------------------------------------------
module tb_cache_plru_update;
  import cache_pkg::*;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_op;
  logic [INDEX-1:0]    req_set;
  logic [WAYS_REP-1:0] req_way;
  logic                req_ready;
  logic                qry_valid;
  logic [INDEX-1:0]    qry_set;
  logic                victim_valid;
  logic [WAYS_REP-1:0] victim_way;
  logic [WAYS-2:0]     victim_bits;
  logic                clr_start;
  logic                clr_busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] model [SETS];

  cache_plru_update dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_set      (req_set),
    .req_way      (req_way),
    .req_ready    (req_ready),
    .qry_valid    (qry_valid),
    .qry_set      (qry_set),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .victim_bits  (victim_bits),
    .clr_start    (clr_start),
    .clr_busy     (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk root-to-leaf; at each level the way bit picks the child,
  // the node stores 1 when the accessed half is the upper one (TOUCH).
  function automatic logic [6:0] m_apply(logic [6:0] t, int w, int demote);
    int node = 0;
    for (int lvl = 2; lvl >= 0; lvl--) begin
      int b = (w >> lvl) & 1;
      t[node] = 1'((b ^ demote) & 1);
      node = 2 * node + 1 + b;
    end
    return t;
  endfunction

  function automatic int m_victim(logic [6:0] t);
    int node = 0;
    int w = 0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      int go = t[node] ? 0 : 1;
      w = 2 * w + go;
      node = 2 * node + 1 + go;
    end
    return w;
  endfunction

  task automatic m_clear_all();
    for (int i = 0; i < SETS; i++) model[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rv, input bit op, input int s, input int w,
                       input bit qv, input int qs);
    req_valid = rv;
    req_op    = op;
    req_set   = s[INDEX-1:0];
    req_way   = w[WAYS_REP-1:0];
    qry_valid = qv;
    qry_set   = qs[INDEX-1:0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    clr_start = 1'b0;
  endtask

  // One cycle with an optional update and optional query, with model tracking.
  task automatic cyc(input bit rv, input bit op, input int s, input int w,
                     input bit qv, input int qs);
    drive(rv, op, s, w, qv, qs);
    if (rv) model[s] = m_apply(model[s], w, int'(op));
    tick();
    idle();
  endtask

  task automatic query_expect(input string tag, input int s, input int exp_way,
                              input int exp_bits);
    cyc(0, 0, 0, 0, 1, s);
    chk({tag, "_valid"}, 32'(victim_valid), 1);
    chk({tag, "_way"}, 32'(victim_way), exp_way);
    chk({tag, "_bits"}, 32'(victim_bits), exp_bits);
  endtask

  initial begin
    int n, rbad, vbad;
    int rsets [4];
    int exp_way, exp_bits;
    bit rv, op, qv;
    int rs, rw, qs;

    rst = 1'b1;
    idle();
    m_clear_all();
    tick();
    tick();
    $display("reset: valid=%0d way=%0d bits=%0d busy=%0d ready=%0d",
             victim_valid, victim_way, victim_bits, clr_busy, req_ready);
    chk("rst_valid", 32'(victim_valid), 0);
    chk("rst_way", 32'(victim_way), 0);
    chk("rst_bits", 32'(victim_bits), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_ready", 32'(req_ready), 1);
    rst = 1'b0;

    query_expect("q_set0", 0, 7, 0);
    query_expect("q_setlast", SETS - 1, 7, 0);

    // Touch all ways of set 5 in order.
    for (int w = 0; w < 8; w++) cyc(1, 0, 5, w, 0, 0);
    query_expect("touch_all", 5, 0, 7'h7f);
    $display("touch ways 0..7 set 5: way=%0d bits=%02h", victim_way, victim_bits);

    // No query: valid drops, outputs hold.
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_valid", 32'(victim_valid), 0);
    chk("hold_way", 32'(victim_way), 0);
    chk("hold_bits", 32'(victim_bits), 7'h7f);

    // Same-cycle touch + query (forwarding).
    cyc(1, 0, 5, 0, 1, 5);
    chk("fwd_touch0_way", 32'(victim_way), 4);
    $display("touch way 0 + query set 5: way=%0d", victim_way);

    cyc(1, 0, 9, 7, 1, 9);
    chk("fwd_set9_valid", 32'(victim_valid), 1);
    chk("fwd_set9_way", 32'(victim_way), 3);
    chk("fwd_set9_bits", 32'(victim_bits), 7'b1000101);
    $display("touch way 7 + query set 9: way=%0d bits=%02h", victim_way, victim_bits);

    cyc(1, 1, 9, 7, 1, 9);
    chk("demote7_way", 32'(victim_way), 7);
    $display("demote way 7 + query set 9: way=%0d", victim_way);

    // Sweep clear.
    cyc(1, 0, 1, 2, 0, 0);
    cyc(1, 0, 100, 5, 0, 0);
    query_expect("pre_clr_s1", 1, m_victim(model[1]), int'(model[1]));
    clr_start = 1'b1;
    tick();
    idle();
    m_clear_all();
    n = 0; rbad = 0; vbad = 0;
    drive(1, 0, 1, 0, 1, 1);
    clr_start = 1'b1;
    while (clr_busy === 1'b1 && n < SETS + 8) begin
      if (req_ready !== 1'b0) rbad++;
      if (victim_valid !== 1'b0) vbad++;
      n++;
      tick();
    end
    idle();
    $display("sweep: busy_cycles=%0d ready_bad=%0d valid_bad=%0d", n, rbad, vbad);
    chk("clr_cycles", 32'(n), SETS);
    chk("clr_ready_low", 32'(rbad), 0);
    chk("clr_valid_low", 32'(vbad), 0);
    chk("clr_exit_valid", 32'(victim_valid), 0);
    query_expect("post_clr_s1", 1, 7, 0);
    query_expect("post_clr_s100", 100, 7, 0);

    // Reset in the middle of a sweep.
    cyc(1, 0, 200, 3, 0, 0);
    cyc(1, 0, SETS - 1, 0, 1, 200);
    clr_start = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 50; i++) tick();
    chk("mid_busy", 32'(clr_busy), 1);
    rst = 1'b1;
    tick();
    m_clear_all();
    $display("reset mid-sweep: busy=%0d ready=%0d valid=%0d",
             clr_busy, req_ready, victim_valid);
    chk("rstmid_busy", 32'(clr_busy), 0);
    chk("rstmid_ready", 32'(req_ready), 1);
    chk("rstmid_valid", 32'(victim_valid), 0);
    rst = 1'b0;
    query_expect("rstmid_s200", 200, 7, 0);
    query_expect("rstmid_slast", SETS - 1, 7, 0);

    // Random TOUCH/DEMOTE stream over four sets.
    rsets[0] = 3; rsets[1] = 77; rsets[2] = 1000; rsets[3] = SETS - 1;
    exp_way = 0; exp_bits = 0;
    for (int i = 0; i < 10000; i++) begin
      rv = 1'($urandom_range(0, 1));
      op = 1'($urandom_range(0, 1));
      rs = rsets[$urandom_range(0, 3)];
      rw = int'($urandom_range(0, 7));
      qv = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      qs = rsets[$urandom_range(0, 3)];
      drive(rv, op, rs, rw, qv, qs);
      if (rv) model[rs] = m_apply(model[rs], rw, int'(op));
      if (qv) begin
        exp_bits = int'(model[qs]);
        exp_way  = m_victim(model[qs]);
      end
      tick();
      if (i < 8 || (i % 1000) == 0) begin
        $display("rand %0d: req=%0d op=%0d set=%0d way=%0d qry=%0d qset=%0d -> valid=%0d way=%0d bits=%02h",
                 i, rv, op, rs, rw, qv, qs, victim_valid, victim_way, victim_bits);
      end
      chk("rand_valid", 32'(victim_valid), 32'(qv));
      chk("rand_way", 32'(victim_way), exp_way);
      chk("rand_bits", 32'(victim_bits), exp_bits);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
